// File: rtl/filter_pipe.sv
// filter_pipe: elastic multi-stage pipeline. Each stage either rotates a beat left
// through its parity bit (mode=0) or passes it through unchanged (mode=1). The mode
// bit travels with the beat. Empty stages collapse forward even when the output is
// stalled, and the input side accepts in the same cycle that a full pipe drains.
module filter_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               io_x_data,
  input  logic                           io_x_parity,
  input  logic                           io_x_valid,
  input  logic                           io_x_mode,
  output logic                           io_x_ready,
  output logic [WIDTH-1:0]               io_y_data,
  output logic                           io_y_parity,
  output logic                           io_y_valid,
  input  logic                           io_y_ready,
  output logic [$clog2(STAGES+1)-1:0]    io_count
);

  localparam int unsigned CW = $clog2(STAGES + 1);

  logic [STAGES-1:0][WIDTH-1:0] data_q;
  logic [STAGES-1:0]            par_q;
  logic [STAGES-1:0]            mode_q;
  logic [STAGES-1:0]            valid_q;

  logic [STAGES-1:0][WIDTH-1:0] src_data;
  logic [STAGES-1:0]            src_par;
  logic [STAGES-1:0]            src_mode;
  logic [STAGES-1:0]            src_valid;
  logic [STAGES-1:0][WIDTH-1:0] nxt_data;
  logic [STAGES-1:0]            nxt_par;
  logic [STAGES-1:0]            load;
  logic [CW-1:0]                cnt;

  // The last stage's mode bit has no downstream consumer.
  logic unused_last_mode;
  assign unused_last_mode = mode_q[STAGES-1];

  // Select each stage's source beat and apply that beat's own transform.
  always_comb begin
    src_data  = '0;
    src_par   = '0;
    src_mode  = '0;
    src_valid = '0;
    nxt_data  = '0;
    nxt_par   = '0;
    src_data[0]  = io_x_data;
    src_par[0]   = io_x_parity;
    src_mode[0]  = io_x_mode;
    src_valid[0] = io_x_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_data[k]  = data_q[k-1];
      src_par[k]   = par_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_valid[k] = valid_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      if (src_mode[k]) begin
        nxt_data[k] = src_data[k];
        nxt_par[k]  = src_par[k];
      end else begin
        nxt_data[k] = {src_data[k][WIDTH-2:0], src_par[k]};
        nxt_par[k]  = src_data[k][WIDTH-1];
      end
    end
  end

  // Stage k can load unless it and every stage after it are full with the output stalled.
  // Written in closed form so no stage's enable feeds back through the same vector.
  always_comb begin
    logic [STAGES-1:0] mask;
    load = '0;
    mask = '0;
    for (int k = 0; k < STAGES; k++) begin
      mask    = {STAGES{1'b1}} << k;
      load[k] = io_y_ready || ((valid_q & mask) != mask);
    end
  end

  // Occupancy is the popcount of the stage valid bits.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < STAGES; k++) begin
      cnt = cnt + CW'(valid_q[k]);
    end
  end

  // Advance the stage registers; a loading stage with no incoming beat becomes a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      par_q   <= '0;
      mode_q  <= '0;
      valid_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) begin
            data_q[k] <= nxt_data[k];
            par_q[k]  <= nxt_par[k];
            mode_q[k] <= src_mode[k];
          end
        end
      end
    end
  end

  assign io_x_ready  = load[0];
  assign io_y_data   = data_q[STAGES-1];
  assign io_y_parity = par_q[STAGES-1];
  assign io_y_valid  = valid_q[STAGES-1];
  assign io_count    = cnt;

endmodule

// File: tb/tb_filter_pipe.sv
// Directed bench for filter_pipe at WIDTH=16, STAGES=2. Inputs change and outputs are
// sampled on the falling edge; expected values are hand-computed.
module tb_filter_pipe;

  logic        clk;
  logic        reset;
  logic [15:0] io_x_data;
  logic        io_x_parity;
  logic        io_x_valid;
  logic        io_x_mode;
  logic        io_x_ready;
  logic [15:0] io_y_data;
  logic        io_y_parity;
  logic        io_y_valid;
  logic        io_y_ready;
  logic [1:0]  io_count;

  int checks = 0;
  int errors = 0;

  filter_pipe #(.WIDTH(16), .STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .io_x_data   (io_x_data),
    .io_x_parity (io_x_parity),
    .io_x_valid  (io_x_valid),
    .io_x_mode   (io_x_mode),
    .io_x_ready  (io_x_ready),
    .io_y_data   (io_y_data),
    .io_y_parity (io_y_parity),
    .io_y_valid  (io_y_valid),
    .io_y_ready  (io_y_ready),
    .io_count    (io_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [15:0] d, input logic p, input logic m);
    io_x_valid  = v;
    io_x_data   = d;
    io_x_parity = p;
    io_x_mode   = m;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    io_y_ready = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #3;
    checks++; if (io_y_valid !== 1'b0) begin errors++; $display("FAIL rst_y_valid: got %b want 0", io_y_valid); end
    checks++; if (io_y_data !== 16'h0) begin errors++; $display("FAIL rst_y_data: got %h want 0000", io_y_data); end
    checks++; if (io_y_parity !== 1'b0) begin errors++; $display("FAIL rst_y_parity: got %b want 0", io_y_parity); end
    checks++; if (io_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", io_count); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (io_x_ready !== 1'b1) begin errors++; $display("FAIL rst_x_ready: got %b want 1", io_x_ready); end
  endtask

  // 0x8001,p0 rotated twice: 0x0002,p1 then 0x0005,p0.
  task automatic test_rotate;
    @(negedge clk);
    io_y_ready = 1'b1;
    drive(1'b1, 16'h8001, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (io_y_valid !== 1'b0) begin errors++; $display("FAIL rot_early_valid: got %b want 0", io_y_valid); end
    @(negedge clk);
    checks++; if (io_y_valid !== 1'b1) begin errors++; $display("FAIL rot_valid: got %b want 1", io_y_valid); end
    checks++; if (io_y_data !== 16'h0005) begin errors++; $display("FAIL rot_data: got %h want 0005", io_y_data); end
    checks++; if (io_y_parity !== 1'b0) begin errors++; $display("FAIL rot_parity: got %b want 0", io_y_parity); end
    @(negedge clk);
    checks++; if (io_y_valid !== 1'b0) begin errors++; $display("FAIL rot_one_cycle: got %b want 0", io_y_valid); end
  endtask

  // Alternating modes back to back; each beat must use its own captured mode.
  task automatic test_mixed_modes;
    logic [15:0] in_d [4] = '{16'h1234, 16'h8001, 16'hABCD, 16'h4000};
    logic        in_p [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        in_m [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] ex_d [4] = '{16'h1234, 16'h0007, 16'hABCD, 16'h0000};
    logic        ex_p [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    io_y_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (io_y_valid !== 1'b1 || io_y_data !== ex_d[i-2] || io_y_parity !== ex_p[i-2]) begin
          errors++;
          $display("FAIL mixed_beat%0d: got v=%b d=%h p=%b want v=1 d=%h p=%b", i - 2, io_y_valid,
                   io_y_data, io_y_parity, ex_d[i-2], ex_p[i-2]);
        end
      end
      if (i < 4) drive(1'b1, in_d[i], in_p[i], in_m[i]);
      else drive(1'b0, 16'h0, 1'b0, ~in_m[3]);
    end
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    io_y_ready = 1'b0;
    drive(1'b1, 16'h0111, 1'b0, 1'b1);
    #1;
    checks++; if (io_x_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy1: got %b want 1", io_x_ready); end
    @(negedge clk);
    drive(1'b1, 16'h0222, 1'b0, 1'b1);
    #1;
    checks++; if (io_x_ready !== 1'b1) begin errors++; $display("FAIL bp_rdy2: got %b want 1", io_x_ready); end
    @(negedge clk);
    drive(1'b1, 16'h0333, 1'b0, 1'b1);
    #1;
    checks++; if (io_x_ready !== 1'b0) begin errors++; $display("FAIL bp_rdy3: got %b want 0", io_x_ready); end
    checks++; if (io_count !== 2'd2) begin errors++; $display("FAIL bp_count: got %0d want 2", io_count); end
    checks++; if (io_y_valid !== 1'b1 || io_y_data !== 16'h0111) begin errors++; $display("FAIL bp_head: got v=%b d=%h want v=1 d=0111", io_y_valid, io_y_data); end
    @(negedge clk);
    checks++; if (io_y_data !== 16'h0111) begin errors++; $display("FAIL bp_stable: got %h want 0111", io_y_data); end
    io_y_ready = 1'b1;
    #1;
    checks++; if (io_x_ready !== 1'b1) begin errors++; $display("FAIL bp_full_accept: got %b want 1", io_x_ready); end
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (io_y_valid !== 1'b1 || io_y_data !== 16'h0222) begin errors++; $display("FAIL bp_beat2: got v=%b d=%h want v=1 d=0222", io_y_valid, io_y_data); end
    @(negedge clk);
    checks++; if (io_y_valid !== 1'b1 || io_y_data !== 16'h0333) begin errors++; $display("FAIL bp_beat3: got v=%b d=%h want v=1 d=0333", io_y_valid, io_y_data); end
    @(negedge clk);
    checks++; if (io_y_valid !== 1'b0 || io_count !== 2'd0) begin errors++; $display("FAIL bp_drained: got v=%b cnt=%0d want v=0 cnt=0", io_y_valid, io_count); end
  endtask

  task automatic test_back_to_back;
    int n_in  = 0;
    int n_out = 0;
    io_y_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i < 12) drive(1'b1, 16'h1000 + 16'(i), i[0], 1'b1);
      else drive(1'b0, 16'h0, 1'b0, 1'b0);
      #1;
      if (i >= 2) begin
        checks++;
        if (io_y_valid !== 1'b1 || io_y_data !== 16'h1000 + 16'(i - 2) || io_y_parity !== i[0]) begin
          errors++;
          $display("FAIL b2b_beat%0d: got v=%b d=%h p=%b want v=1 d=%h p=%b", i - 2, io_y_valid,
                   io_y_data, io_y_parity, 16'h1000 + 16'(i - 2), i[0]);
        end
      end
      if (i >= 2 && i <= 11) begin
        checks++; if (io_count !== 2'd2) begin errors++; $display("FAIL b2b_count%0d: got %0d want 2", i, io_count); end
        if (io_x_valid && io_x_ready) n_in++;
        if (io_y_valid && io_y_ready) n_out++;
      end
    end
    checks++; if (n_in != 10) begin errors++; $display("FAIL b2b_in_xfers: got %0d want 10", n_in); end
    checks++; if (n_out != 10) begin errors++; $display("FAIL b2b_out_xfers: got %0d want 10", n_out); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    io_y_ready = 1'b0;
    drive(1'b1, 16'h5555, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 16'h6666, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (io_count !== 2'd2) begin errors++; $display("FAIL ar_pre_count: got %0d want 2", io_count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (io_y_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", io_y_valid); end
    checks++; if (io_count !== 2'd0) begin errors++; $display("FAIL ar_count: got %0d want 0", io_count); end
    checks++; if (io_y_data !== 16'h0 || io_y_parity !== 1'b0) begin errors++; $display("FAIL ar_data: got d=%h p=%b want d=0000 p=0", io_y_data, io_y_parity); end
    @(negedge clk);
    reset = 1'b1;
    io_y_ready = 1'b1;
    drive(1'b1, 16'h8001, 1'b0, 1'b0);
    #1;
    checks++; if (io_x_ready !== 1'b1) begin errors++; $display("FAIL ar_x_ready: got %b want 1", io_x_ready); end
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (io_y_valid !== 1'b0) begin errors++; $display("FAIL ar_no_stale: got %b want 0", io_y_valid); end
    @(negedge clk);
    checks++; if (io_y_valid !== 1'b1 || io_y_data !== 16'h0005) begin errors++; $display("FAIL ar_new_beat: got v=%b d=%h want v=1 d=0005", io_y_valid, io_y_data); end
  endtask

  task automatic test_bubble;
    @(negedge clk);
    io_y_ready = 1'b0;
    drive(1'b1, 16'h00AA, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    checks++; if (io_count !== 2'd1 || io_y_valid !== 1'b0) begin errors++; $display("FAIL bub_stage0: got cnt=%0d v=%b want cnt=1 v=0", io_count, io_y_valid); end
    @(negedge clk);
    checks++; if (io_y_valid !== 1'b1 || io_y_data !== 16'h00AA) begin errors++; $display("FAIL bub_moved: got v=%b d=%h want v=1 d=00aa", io_y_valid, io_y_data); end
    checks++; if (io_x_ready !== 1'b1) begin errors++; $display("FAIL bub_x_ready: got %b want 1", io_x_ready); end
    checks++; if (io_count !== 2'd1) begin errors++; $display("FAIL bub_count: got %0d want 1", io_count); end
    io_y_ready = 1'b1;
    @(negedge clk);
    checks++; if (io_y_valid !== 1'b0) begin errors++; $display("FAIL bub_drain: got %b want 0", io_y_valid); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_mixed_modes();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_bubble();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
